// File: rtl/ps2_rx_control.sv
// PS/2 receive front end: synchronises and de-glitches ClkKB/DataKB, and sequences
// the external frame capture stage (Load/New/Borrar) with a stalled-frame watchdog.
module ps2_rx_control #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic ClkKB,
  input  logic DataKB,
  input  logic EndTras,
  input  logic ParityCoherente,
  output logic DataKBSync,
  output logic Load,
  output logic New,
  output logic Borrar,
  output logic FrameError,
  output logic Busy
);

  // state      | meaning
  // S_IDLE     | waiting for the first falling ClkKB edge of a frame
  // S_RECV     | counting shift strobes, watchdog running
  // S_WAIT_END | capture stage registers EndTras for the 11th bit
  // S_CHECK    | judge frame: New or FrameError
  // S_CLEAR    | Borrar clears the capture stage bit counter
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WAIT_END, S_CHECK, S_CLEAR} state_t;

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     LAST_BIT = 4'd11;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic [FCW-1:0]         filt_cnt_q, filt_cnt_d, filt_inc;
  logic                   filt_lvl_q, filt_lvl_d;
  logic                   filt_prev_q;
  logic                   fall_edge;
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d, bit_inc;
  logic [WDW-1:0]         wd_q, wd_d, wd_inc;

  assign DataKBSync = data_sync_q[SYNC_STAGES-1];
  assign filt_inc   = filt_cnt_q + FCW'(1);
  assign fall_edge  = filt_prev_q & ~filt_lvl_q;
  assign bit_inc    = bit_cnt_q + 4'd1;
  assign wd_inc     = (wd_q == WD_MAX) ? wd_q : wd_q + WDW'(1);

  always_comb begin
    filt_cnt_d = '0;
    filt_lvl_d = filt_lvl_q;
    if (clk_sync_q[SYNC_STAGES-1] != filt_lvl_q) begin
      if (filt_inc == FILT_MAX) filt_lvl_d = ~filt_lvl_q;
      else                      filt_cnt_d = filt_inc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_cnt_q  <= '0;
      filt_lvl_q  <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      wd_q        <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ClkKB};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], DataKB};
      filt_cnt_q  <= filt_cnt_d;
      filt_lvl_q  <= filt_lvl_d;
      filt_prev_q <= filt_lvl_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      wd_q        <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wd_d       = '0;
    Load       = 1'b0;
    New        = 1'b0;
    Borrar     = 1'b0;
    FrameError = 1'b0;
    Busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_edge) begin
          Load      = 1'b1;
          bit_cnt_d = 4'd1;
          state_d   = S_RECV;
        end
      end
      S_RECV: begin
        Busy = 1'b1;
        // A falling edge in the same cycle as expiry keeps the frame alive.
        if (fall_edge) begin
          Load      = 1'b1;
          bit_cnt_d = bit_inc;
          if (bit_inc == LAST_BIT) state_d = S_WAIT_END;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WD_MAX) begin
            FrameError = 1'b1;
            state_d    = S_CLEAR;
          end
        end
      end
      S_WAIT_END: begin
        Busy    = 1'b1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        Busy = 1'b1;
        if (EndTras && ParityCoherente) New = 1'b1;
        else                            FrameError = 1'b1;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        Borrar    = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_rx_control.sv
// Self-checking bench for ps2_rx_control with a behavioural frame capture stage
// attached; expected outcomes come from the PS/2 frame rules applied to each sent frame.
module tb_ps2_rx_control;

  localparam int SYNC = 2;
  localparam int FL   = 4;
  localparam int TO   = 300;

  logic Clk = 1'b0;
  logic Reset, ClkKB, DataKB;
  logic EndTras, ParityCoherente;
  logic DataKBSync, Load, New, Borrar, FrameError, Busy;

  always #5 Clk = ~Clk;

  ps2_rx_control #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .ClkKB(ClkKB), .DataKB(DataKB),
    .EndTras(EndTras), .ParityCoherente(ParityCoherente),
    .DataKBSync(DataKBSync), .Load(Load), .New(New), .Borrar(Borrar),
    .FrameError(FrameError), .Busy(Busy)
  );

  // Behavioural capture stage: shifts LSB first on Load, registered EndTras.
  logic [10:0] cap_sh;
  logic [3:0]  cap_cnt;
  logic        end_q;
  logic [7:0]  scan_code;

  always @(posedge Clk) begin
    if (Reset) begin
      cap_sh  <= '0;
      cap_cnt <= '0;
      end_q   <= 1'b0;
    end else begin
      if (Borrar) cap_cnt <= '0;
      else if (Load && cap_cnt < 4'd11) begin
        cap_sh  <= {DataKBSync, cap_sh[10:1]};
        cap_cnt <= cap_cnt + 4'd1;
      end
      end_q <= (cap_cnt == 4'd11);
      if (New) scan_code <= cap_sh[8:1];
    end
  end

  assign EndTras         = end_q;
  assign ParityCoherente = ~cap_sh[0] & cap_sh[10] & (^cap_sh[9:1]);

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Event monitor, sampled on the falling Clk edge.
  int cyc = 0;
  int last_load_cyc = 0;
  int fe_gap = 0;
  int n_load, n_new, n_fe, n_borrar;
  logic prev_nf = 1'b0;

  task automatic clear_counts();
    n_load = 0; n_new = 0; n_fe = 0; n_borrar = 0; fe_gap = -1;
  endtask

  initial begin
    clear_counts();
    forever begin
      @(negedge Clk);
      cyc++;
      if (Reset) prev_nf = 1'b0;
      else begin
        if (prev_nf || Borrar) check_eq("borrar_follows", Borrar, prev_nf);
        if (New || FrameError) check_eq("new_ferr_excl", New & FrameError, 0);
        if (New) check_eq("new_latency", cyc - last_load_cyc, 2);
        if (Load) begin
          n_load++;
          last_load_cyc = cyc;
        end
        if (New) n_new++;
        if (FrameError) begin
          if (n_fe == 0) fe_gap = cyc - last_load_cyc;
          n_fe++;
        end
        if (Borrar) n_borrar++;
        prev_nf = New | FrameError;
      end
    end
  end

  // err: 0 valid, 1 parity flipped, 2 stop bit 0, 3 start bit 1
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input int err);
    logic par;
    par = ~^d;
    if (err == 1) par = ~par;
    return {(err == 2) ? 1'b0 : 1'b1, par, d, (err == 3) ? 1'b1 : 1'b0};
  endfunction

  task automatic send_bit(input logic b, input int h, input bit glitch);
    DataKB = b;
    if (glitch) begin
      repeat (4) @(negedge Clk);
      ClkKB = 1'b0;
      repeat (FL - 1) @(negedge Clk);
      ClkKB = 1'b1;
      repeat (h - 4 - (FL - 1)) @(negedge Clk);
    end else begin
      repeat (h) @(negedge Clk);
    end
    ClkKB = 1'b0;
    repeat (h) @(negedge Clk);
    ClkKB = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input int err, input int h, input int glitch_bit);
    logic [10:0] f;
    logic ok;
    f  = mk_frame(d, err);
    ok = (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
    clear_counts();
    for (int i = 0; i < 11; i++) begin
      send_bit(f[i], h, i == glitch_bit);
      if (i == 3) check_eq("busy_in_frame", Busy, 1);
    end
    DataKB = 1'b1;
    repeat (40) @(negedge Clk);
    check_eq("load_count", n_load, 11);
    check_eq("new_count", n_new, {31'd0, ok});
    check_eq("ferr_count", n_fe, {31'd0, ~ok});
    check_eq("borrar_count", n_borrar, 1);
    check_eq("busy_after", Busy, 0);
    if (ok) check_eq("scan_code", scan_code, d);
  endtask

  initial begin
    logic [10:0] f;
    int r;
    Reset  = 1'b1;
    ClkKB  = 1'b1;
    DataKB = 1'b1;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    check_eq("rst_load", Load, 0);
    check_eq("rst_new", New, 0);
    check_eq("rst_borrar", Borrar, 0);
    check_eq("rst_ferr", FrameError, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_datasync", DataKBSync, 1);
    repeat (10) @(negedge Clk);

    run_frame(8'h1C, 0, 20, -1);
    run_frame(8'h1C, 1, 20, -1);
    run_frame(8'hF0, 0, 20, -1);
    run_frame(8'h1C, 2, 20, -1);

    // Stalled frame: 5 bits then the line stays high.
    clear_counts();
    f = mk_frame(8'h1C, 0);
    for (int i = 0; i < 5; i++) send_bit(f[i], 16, 1'b0);
    DataKB = 1'b1;
    repeat (TO + 40) @(negedge Clk);
    check_eq("to_load_count", n_load, 5);
    check_eq("to_ferr_count", n_fe, 1);
    check_eq("to_ferr_gap", fe_gap, TO);
    check_eq("to_new_count", n_new, 0);
    check_eq("to_borrar_count", n_borrar, 1);
    check_eq("to_busy_after", Busy, 0);
    run_frame(8'hA5, 0, 18, -1);

    // Short and long clock glitches while idle.
    clear_counts();
    ClkKB = 1'b0;
    repeat (FL - 1) @(negedge Clk);
    ClkKB = 1'b1;
    repeat (TO + 40) @(negedge Clk);
    check_eq("glitch_idle_load", n_load, 0);
    check_eq("glitch_idle_ferr", n_fe, 0);
    clear_counts();
    ClkKB = 1'b0;
    repeat (FL + 2) @(negedge Clk);
    ClkKB = 1'b1;
    repeat (TO + 40) @(negedge Clk);
    check_eq("long_glitch_load", n_load, 1);
    check_eq("long_glitch_ferr", n_fe, 1);
    check_eq("long_glitch_gap", fe_gap, TO);
    check_eq("long_glitch_borrar", n_borrar, 1);

    // Short glitch during reception must not add a bit.
    run_frame(8'h5A, 0, 20, 4);

    // Reset after 6 bits.
    clear_counts();
    f = mk_frame(8'h3C, 0);
    for (int i = 0; i < 6; i++) send_bit(f[i], 16, 1'b0);
    DataKB = 1'b1;
    check_eq("busy_before_reset", Busy, 1);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("mid_rst_load", Load, 0);
    check_eq("mid_rst_new", New, 0);
    check_eq("mid_rst_borrar", Borrar, 0);
    check_eq("mid_rst_ferr", FrameError, 0);
    check_eq("mid_rst_busy", Busy, 0);
    clear_counts();
    repeat (TO + 40) @(negedge Clk);
    check_eq("post_rst_ferr", n_fe, 0);
    check_eq("post_rst_load", n_load, 0);
    run_frame(8'h1C, 0, 20, -1);

    // Randomised frames: data, error kind and bit period.
    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 5));
      run_frame(8'($urandom_range(0, 255)), (r > 2) ? r - 2 : 0,
                int'($urandom_range(12, 30)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ps2_rx_control.md
Name: ps2_rx_control

Overview:
- Front-end controller for the PS/2 keyboard receive path.
- Synchronises and de-glitches the raw keyboard clock and data lines, and sequences the frame capture stage that shifts in the 11-bit frame.
- Drives that stage's Load, New and Borrar inputs and passes it a synchronised DataKB.
- Judges frame completion and validity from its EndTras and ParityCoherente outputs, with a watchdog that discards stalled frames.

Parameters:
- SYNC_STAGES, 2: flops in each input synchroniser (≥2).
- FILTER_LEN, 4: consecutive identical synchronised ClkKB samples needed to change the filtered clock level. Must satisfy SYNC_STAGES+FILTER_LEN+1 < 5 µs in Clk periods.
- TIMEOUT_CYCLES, 100000: Clk cycles without a falling edge in RECV before the frame is aborted (2 ms at 50 MHz).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- ClkKB  in  1  raw PS/2 clock, asynchronous
- DataKB  in  1  raw PS/2 data, asynchronous
- EndTras  in  1  frame capture stage: 11 bits shifted
- ParityCoherente  in  1  frame capture stage: start=0, stop=1, odd parity correct
- DataKBSync  out  1  synchronised data, to capture stage DataKB
- Load  out  1  one-cycle shift strobe
- New  out  1  one-cycle valid-frame strobe
- Borrar  out  1  one-cycle bit-counter clear
- FrameError  out  1  one-cycle strobe: bad parity/framing, count mismatch or timeout
- Busy  out  1  high while a frame is in progress

Behaviour:
- Reset: synchroniser flops and filtered clock = 1; FSM = IDLE; bit count = 0; watchdog = 0; Load/New/Borrar/FrameError/Busy = 0; DataKBSync = 1.
- Reset mid-frame: immediate return to IDLE, partial frame discarded. The capture stage shares Reset, so no Borrar is issued.
- Synchronisers: ClkKB and DataKB each pass through SYNC_STAGES flops. DataKBSync is the last data-synchroniser stage.
- Glitch filter:
  - Counter increments while the synchronised ClkKB differs from the filtered level; clears when they match.
  - When the counter reaches FILTER_LEN, the filtered level toggles and the counter clears.
  - Low pulses shorter than FILTER_LEN cycles produce no edge.
- Edge detect: Load = 1 for exactly the one cycle after the filtered level goes 1→0. Load is generated only in IDLE and RECV. Edges in WAIT_END, CHECK or CLEAR are dropped.
- FSM states:
  - IDLE: Busy=0. Load → RECV, bit count = 1, watchdog cleared.
  - RECV: Busy=1.
    - Each Load: bit count +1, watchdog cleared.
    - Otherwise the watchdog increments.
    - When Load brings the count to 11 → WAIT_END.
    - Watchdog == TIMEOUT_CYCLES → FrameError=1 for one cycle → CLEAR.
  - WAIT_END: Busy=1. Single cycle that lets the capture stage register EndTras → CHECK.
  - CHECK: Busy=1.
    - EndTras=1 and ParityCoherente=1 → New=1 for one cycle.
    - Otherwise FrameError=1 for one cycle.
    - Either way → CLEAR.
  - CLEAR: Borrar=1 for one cycle, bit count = 0 → IDLE.
- New and FrameError are mutually exclusive. Each occurs at most once per frame and is always followed by Borrar on the next cycle.
- Latency: New asserts 2 cycles after the 11th Load. The capture stage's NewScanCode follows 1 cycle later. ScanCode stays held until the next frame's first Load (Borrar does not clear data).
- Bit count is 4 bits and never exceeds 11. The watchdog is sized to hold TIMEOUT_CYCLES and saturates.
- Simultaneous Load and watchdog expiry in RECV: Load wins and the watchdog clears.
- Power-up with keyboard mid-frame: the first partial frame ends in a timeout or error, then normal operation resumes.

Test Plan:
- Valid frame 0x1C (bits LSB-first 0 | 0,0,1,1,1,0,0,0 | parity 0 | stop 1), 12.5 kHz ClkKB, with capture stage attached → 11 Load pulses, New once, Borrar next cycle, FrameError=0, ScanCode=0x1C, Busy low after CLEAR.
- Same frame with parity bit 1 → no New, FrameError once, Borrar next cycle. The next valid frame 0xF0 yields New with ScanCode=0xF0.
- 5 bits sent then ClkKB held high → FrameError exactly TIMEOUT_CYCLES after the 5th Load, then Borrar, then IDLE. A following valid frame decodes correctly.
- ClkKB low glitch of FILTER_LEN-1 cycles in IDLE and in RECV → no Load, bit count unchanged. A glitch of FILTER_LEN+2 cycles → exactly one Load.
- Reset asserted after 6 bits → all outputs 0 the cycle after, FSM in IDLE. A next valid frame 0x1C gives New with ScanCode=0x1C.
- Stop bit 0 with correct parity → FrameError, no New.
